icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines (power of two).
REQ-002 Parameter WORDS, default 4, 32-bit words per line (power of two).
REQ-003 CLK  input  1  single clock; all state updates on posedge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 Addr_IN  input  32  fetch address from the fetch stage; bits [1:0] ignored.
REQ-006 Read_IN  input  1  fetch request valid this cycle.
REQ-007 Flush_IN  input  1  invalidate all lines.
REQ-008 Instr_OUT  output  32  instruction word for Addr_IN.
REQ-009 Stall_OUT  output  1  high = Instr_OUT not valid; fetch stage holds its PC.
REQ-010 Mem_Req_OUT  output  1  line refill request to memory.
REQ-011 Mem_Addr_OUT  output  32  line-aligned refill address.
REQ-012 Mem_Ack_IN  input  1  one-cycle pulse: memory accepted request.
REQ-013 Mem_Data_IN  input  32  refill data beat.
REQ-014 Mem_Data_Valid_IN  input  1  Mem_Data_IN valid this cycle.
REQ-015 Hit_Count_OUT, Miss_Count_OUT  output  16 each  saturating statistics counters.

Function
REQ-016 Address split: offset = Addr_IN[log2(WORDS)+1:2], index = next log2(LINES) bits, tag = remaining upper bits (24 bits at defaults).
REQ-017 States: IDLE, MISS_REQ, REFILL; IDLE is the lookup state.
REQ-018 Hit = state IDLE, Read_IN high, line valid, stored tag equals tag; combinational.
REQ-019 On hit, Instr_OUT = stored word at index/offset and Stall_OUT = 0 in the same cycle (zero-latency hit); otherwise Instr_OUT = 0.
REQ-020 Stall_OUT = Read_IN and not hit; Stall_OUT = 1 in MISS_REQ and REFILL regardless of Read_IN.
REQ-021 IDLE, Read_IN high, miss, Flush_IN low -> latch line address {tag,index,0}, go MISS_REQ; Miss_Count_OUT increments once.
REQ-022 Each hit cycle increments Hit_Count_OUT; both counters stick at 16'hFFFF.
REQ-023 MISS_REQ: Mem_Req_OUT = 1 and Mem_Addr_OUT = latched line address, held stable until Mem_Ack_IN; on Mem_Ack_IN go REFILL, Mem_Req_OUT drops next cycle.
REQ-024 REFILL: each Mem_Data_Valid_IN writes Mem_Data_IN to word beat_count (0..WORDS-1, ascending) of the latched line; gaps between beats allowed.
REQ-025 On the final beat: write tag, set valid, go IDLE; lookup of the same address hits the following cycle.
REQ-026 Line valid bit is cleared at the MISS_REQ entry edge so a partial refill never hits.
REQ-027 Addr_IN changes during MISS_REQ/REFILL are ignored; the started refill completes, then IDLE re-evaluates current Addr_IN.
REQ-028 Mem_Ack_IN and Mem_Data_Valid_IN are ignored in states that do not expect them.
REQ-029 Flush_IN in IDLE: clear all valid bits at the edge; that cycle reports Stall_OUT per REQ-020 but starts no refill.
REQ-030 Flush_IN during MISS_REQ/REFILL: refill completes but the line is not marked valid; all other valid bits cleared.
REQ-031 Mem_Addr_OUT = 0 outside MISS_REQ.

Reset
REQ-032 RESET low: state IDLE, all valid bits 0, beat_count 0, counters 0, Mem_Req_OUT 0, Mem_Addr_OUT 0; data/tag arrays need no reset.
REQ-033 Reset mid-refill abandons the refill; subsequently arriving memory beats are ignored.

Structure
REQ-034 LINES/WORDS defaults, the reset vector 32'hBFC00000 and state encodings live in the shared config include.
REQ-035 Data/tag/valid storage is one sub-module, icache_line_array (one write port, one async read port); FSM and counters stay in icache.

Verification
REQ-036 Reset, Addr_IN=BFC00000, Read_IN=1 -> Stall_OUT=1, Mem_Req_OUT=1 with Mem_Addr_OUT=BFC00000; Ack, 4 beats 11,22,33,44 -> next cycle Instr_OUT=11, Stall_OUT=0, Miss_Count_OUT=1.
REQ-037 After REQ-036, Addr_IN = BFC00004, 08, 0C on consecutive cycles -> Instr_OUT 22,33,44, no stall, Hit_Count_OUT=4.
REQ-038 Addr_IN=BFC00100 (same index 0, new tag) -> refill; then BFC00000 misses again (eviction), Miss_Count_OUT=3.
REQ-039 Ack delayed 5 cycles, beats with 2-cycle gaps, Addr_IN toggled mid-refill -> Mem_Addr_OUT stable, original line filled, then new address evaluated.
REQ-040 Flush_IN during REFILL -> refilled address still misses afterwards; RESET low after beat 2 -> no Mem_Req_OUT, later stray beats write nothing, counters 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared configuration for the instruction cache: geometry defaults, reset
// vector, FSM state encodings and a saturating counter helper.
package icache_pkg;

  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MISS_REQ = 2'd1;
  localparam logic [1:0] ST_REFILL   = 2'd2;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Direct-mapped line storage: word data, tags and per-line valid bits.
// One write port shared by refill, invalidate and flush; asynchronous read.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  parameter int TAG_W = 24,
  localparam int IDX_W = $clog2(LINES),
  localparam int OFF_W = $clog2(WORDS)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic [31:0]      rd_word,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic             word_we,
  input  logic [31:0]      wr_data,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             set_valid,
  input  logic             clr_valid,
  input  logic             clr_all
);

  logic [31:0]      data_mem [LINES*WORDS];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_reg;
  logic [LINES-1:0] valid_next;
  logic [LINES-1:0] line_sel;

  always_ff @(posedge CLK) begin
    if (word_we) data_mem[{wr_index, wr_offset}] <= wr_data;
    if (tag_we)  tag_mem[wr_index] <= wr_tag;
  end

  for (genvar gi = 0; gi < LINES; gi++) begin : g_sel
    localparam logic [IDX_W-1:0] LINE_ID = IDX_W'(gi);
    assign line_sel[gi] = (wr_index == LINE_ID);
  end

  // Flush wins over everything; invalidate and set never coincide.
  always_comb begin
    valid_next = valid_reg;
    if (clr_all)        valid_next = '0;
    else if (clr_valid) valid_next = valid_reg & ~line_sel;
    else if (set_valid) valid_next = valid_reg | line_sel;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) valid_reg <= '0;
    else        valid_reg <= valid_next;
  end

  assign rd_word  = data_mem[{rd_index, rd_offset}];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_reg[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with zero-latency hits and a blocking
// line refill FSM (IDLE lookup, MISS_REQ handshake, REFILL beat collection).
module icache
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Addr_IN,
  input  logic        Read_IN,
  input  logic        Flush_IN,
  output logic [31:0] Instr_OUT,
  output logic        Stall_OUT,
  output logic        Mem_Req_OUT,
  output logic [31:0] Mem_Addr_OUT,
  input  logic        Mem_Ack_IN,
  input  logic [31:0] Mem_Data_IN,
  input  logic        Mem_Data_Valid_IN,
  output logic [15:0] Hit_Count_OUT,
  output logic [15:0] Miss_Count_OUT
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int LO    = OFF_W + 2;
  localparam int TAG_W = 32 - IDX_W - LO;

  logic [1:0]       state_reg;
  logic [31:0]      line_addr_reg;
  logic [OFF_W-1:0] beat_reg;
  logic             flushed_reg;
  logic [15:0]      hit_cnt_reg;
  logic [15:0]      miss_cnt_reg;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [31:0]      rd_word;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_valid;
  logic             is_idle;
  logic             hit;
  logic             miss_start;
  logic             beat_in;
  logic             last_beat;
  logic             unused_bits;

  assign req_off  = Addr_IN[LO-1:2];
  assign req_idx  = Addr_IN[IDX_W+LO-1:LO];
  assign req_tag  = Addr_IN[31:IDX_W+LO];
  assign fill_idx = line_addr_reg[IDX_W+LO-1:LO];
  assign fill_tag = line_addr_reg[31:IDX_W+LO];
  assign unused_bits = ^{Addr_IN[1:0], line_addr_reg[LO-1:0]};

  assign is_idle    = (state_reg == ST_IDLE);
  assign hit        = is_idle && Read_IN && rd_valid && (rd_tag == req_tag);
  assign miss_start = is_idle && Read_IN && !hit && !Flush_IN;
  assign beat_in    = (state_reg == ST_REFILL) && Mem_Data_Valid_IN;
  assign last_beat  = beat_in && (beat_reg == OFF_W'(WORDS - 1));

  // Write port index: lookup index while invalidating at miss entry, else the latched line.
  icache_line_array #(
    .LINES(LINES),
    .WORDS(WORDS),
    .TAG_W(TAG_W)
  ) u_lines (
    .CLK       (CLK),
    .RESET     (RESET),
    .rd_index  (req_idx),
    .rd_offset (req_off),
    .rd_word   (rd_word),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_index  (is_idle ? req_idx : fill_idx),
    .wr_offset (beat_reg),
    .word_we   (beat_in),
    .wr_data   (Mem_Data_IN),
    .tag_we    (last_beat),
    .wr_tag    (fill_tag),
    .set_valid (last_beat && !flushed_reg && !Flush_IN),
    .clr_valid (miss_start),
    .clr_all   (Flush_IN)
  );

  assign Instr_OUT      = hit ? rd_word : 32'd0;
  assign Stall_OUT      = !is_idle || (Read_IN && !hit);
  assign Mem_Req_OUT    = (state_reg == ST_MISS_REQ);
  assign Mem_Addr_OUT   = Mem_Req_OUT ? line_addr_reg : 32'd0;
  assign Hit_Count_OUT  = hit_cnt_reg;
  assign Miss_Count_OUT = miss_cnt_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= ST_IDLE;
      line_addr_reg <= RESET_VECTOR;
      beat_reg      <= '0;
      flushed_reg   <= 1'b0;
      hit_cnt_reg   <= 16'd0;
      miss_cnt_reg  <= 16'd0;
    end else begin
      if (hit) hit_cnt_reg <= sat_inc(hit_cnt_reg);
      case (state_reg)
        ST_IDLE: begin
          if (miss_start) begin
            line_addr_reg <= {req_tag, req_idx, {LO{1'b0}}};
            miss_cnt_reg  <= sat_inc(miss_cnt_reg);
            flushed_reg   <= 1'b0;
            state_reg     <= ST_MISS_REQ;
          end
        end
        ST_MISS_REQ: begin
          if (Flush_IN) flushed_reg <= 1'b1;
          if (Mem_Ack_IN) begin
            beat_reg  <= '0;
            state_reg <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (Flush_IN) flushed_reg <= 1'b1;
          if (beat_in) begin
            beat_reg <= beat_reg + OFF_W'(1);
            if (last_beat) state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss/refill, sequential hits, eviction,
// slow memory with address churn, flush during refill and reset mid-refill.
module tb_icache;

  logic        CLK;
  logic        RESET;
  logic [31:0] Addr_IN;
  logic        Read_IN;
  logic        Flush_IN;
  logic [31:0] Instr_OUT;
  logic        Stall_OUT;
  logic        Mem_Req_OUT;
  logic [31:0] Mem_Addr_OUT;
  logic        Mem_Ack_IN;
  logic [31:0] Mem_Data_IN;
  logic        Mem_Data_Valid_IN;
  logic [15:0] Hit_Count_OUT;
  logic [15:0] Miss_Count_OUT;

  int checks   = 0;
  int failures = 0;

  icache dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .Addr_IN           (Addr_IN),
    .Read_IN           (Read_IN),
    .Flush_IN          (Flush_IN),
    .Instr_OUT         (Instr_OUT),
    .Stall_OUT         (Stall_OUT),
    .Mem_Req_OUT       (Mem_Req_OUT),
    .Mem_Addr_OUT      (Mem_Addr_OUT),
    .Mem_Ack_IN        (Mem_Ack_IN),
    .Mem_Data_IN       (Mem_Data_IN),
    .Mem_Data_Valid_IN (Mem_Data_Valid_IN),
    .Hit_Count_OUT     (Hit_Count_OUT),
    .Miss_Count_OUT    (Miss_Count_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic look();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called on the first MISS_REQ cycle; returns on the first IDLE cycle after the last beat.
  task automatic serve(input logic [31:0] addr, input logic [31:0] alt_addr,
                       input logic [31:0] seed, input int ack_delay, input int gap,
                       input int flush_beat);
    Addr_IN = alt_addr;
    for (int i = 0; i < ack_delay; i++) begin
      look();
      chk("req_hold", Mem_Req_OUT, 1);
      chk("addr_hold", Mem_Addr_OUT, addr);
      tick();
    end
    Mem_Ack_IN = 1'b1;
    look();
    chk("req_ack", Mem_Req_OUT, 1);
    chk("addr_ack", Mem_Addr_OUT, addr);
    chk("stall_req", Stall_OUT, 1);
    tick();
    Mem_Ack_IN = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        Mem_Ack_IN = 1'b1;
        look();
        chk("stall_gap", Stall_OUT, 1);
        chk("addr_zero_gap", Mem_Addr_OUT, 0);
        tick();
        Mem_Ack_IN = 1'b0;
      end
      Mem_Data_Valid_IN = 1'b1;
      Mem_Data_IN = seed * 32'(b + 1);
      Flush_IN = (b == flush_beat);
      look();
      if (b == 0) chk("req_drop", Mem_Req_OUT, 0);
      tick();
      Mem_Data_Valid_IN = 1'b0;
      Mem_Data_IN = 32'd0;
      Flush_IN = 1'b0;
    end
  endtask

  initial begin
    RESET = 1'b0;
    Addr_IN = 32'd0;
    Read_IN = 1'b0;
    Flush_IN = 1'b0;
    Mem_Ack_IN = 1'b0;
    Mem_Data_IN = 32'd0;
    Mem_Data_Valid_IN = 1'b0;
    tick();
    tick();
    look();
    chk("rst_stall", Stall_OUT, 0);
    chk("rst_req", Mem_Req_OUT, 0);
    chk("rst_addr", Mem_Addr_OUT, 0);
    chk("rst_instr", Instr_OUT, 0);
    chk("rst_hits", Hit_Count_OUT, 0);
    chk("rst_miss", Miss_Count_OUT, 0);
    tick();
    RESET = 1'b1;

    // Cold miss on the reset vector, fast memory
    Addr_IN = 32'hBFC00000;
    Read_IN = 1'b1;
    look();
    chk("cold_stall", Stall_OUT, 1);
    chk("cold_req_idle", Mem_Req_OUT, 0);
    chk("cold_instr", Instr_OUT, 0);
    tick();
    serve(32'hBFC00000, 32'hBFC00000, 32'h11, 0, 0, -1);
    look();
    chk("fill_instr0", Instr_OUT, 32'h11);
    chk("fill_stall0", Stall_OUT, 0);
    chk("fill_miss1", Miss_Count_OUT, 1);

    // Remaining words of the line hit back to back
    tick();
    Addr_IN = 32'hBFC00004;
    look();
    chk("hit_w1", Instr_OUT, 32'h22);
    chk("hit_w1_stall", Stall_OUT, 0);
    tick();
    Addr_IN = 32'hBFC00008;
    look();
    chk("hit_w2", Instr_OUT, 32'h33);
    tick();
    Addr_IN = 32'hBFC0000C;
    look();
    chk("hit_w3", Instr_OUT, 32'h44);
    chk("hit_w3_stall", Stall_OUT, 0);
    tick();
    Read_IN = 1'b0;
    look();
    chk("hit_count4", Hit_Count_OUT, 4);
    chk("noread_stall", Stall_OUT, 0);

    // Same index, new tag: refill, then the old line is evicted
    tick();
    Addr_IN = 32'hBFC00100;
    Read_IN = 1'b1;
    look();
    chk("evict_stall", Stall_OUT, 1);
    tick();
    serve(32'hBFC00100, 32'hBFC00100, 32'h55, 0, 0, -1);
    look();
    chk("evict_instr", Instr_OUT, 32'h55);
    tick();
    Addr_IN = 32'hBFC00000;
    look();
    chk("evicted_stall", Stall_OUT, 1);
    chk("evicted_instr", Instr_OUT, 0);
    tick();
    look();
    chk("evicted_miss3", Miss_Count_OUT, 3);
    chk("evicted_addr", Mem_Addr_OUT, 32'hBFC00000);

    // Slow ack, gapped beats, fetch address moved to another line meanwhile
    tick();
    serve(32'hBFC00000, 32'hBFC00044, 32'h11, 5, 2, -1);
    look();
    chk("moved_stall", Stall_OUT, 1);
    chk("moved_req_idle", Mem_Req_OUT, 0);
    tick();
    look();
    chk("moved_addr", Mem_Addr_OUT, 32'hBFC00040);
    chk("moved_miss4", Miss_Count_OUT, 4);
    tick();
    serve(32'hBFC00040, 32'hBFC00044, 32'h70, 1, 0, -1);
    look();
    chk("moved_instr", Instr_OUT, 32'hE0);
    tick();
    Addr_IN = 32'hBFC00008;
    look();
    chk("orig_filled", Instr_OUT, 32'h33);
    chk("orig_stall", Stall_OUT, 0);

    // Flush during refill leaves the line invalid; flush in IDLE starts no refill
    tick();
    Addr_IN = 32'hBFC00200;
    look();
    chk("f_stall", Stall_OUT, 1);
    tick();
    serve(32'hBFC00200, 32'hBFC00200, 32'h90, 0, 0, 1);
    Flush_IN = 1'b1;
    look();
    chk("f_still_miss", Stall_OUT, 1);
    chk("f_instr", Instr_OUT, 0);
    tick();
    Flush_IN = 1'b0;
    Read_IN = 1'b0;
    look();
    chk("f_no_req", Mem_Req_OUT, 0);
    chk("f_miss5", Miss_Count_OUT, 5);
    Addr_IN = 32'hBFC00044;
    Read_IN = 1'b1;
    look();
    chk("f_other_clr", Stall_OUT, 1);
    tick();
    look();
    chk("r_addr", Mem_Addr_OUT, 32'hBFC00040);
    chk("r_miss6", Miss_Count_OUT, 6);

    // Reset after two beats, then stray beats must be ignored
    Mem_Ack_IN = 1'b1;
    tick();
    Mem_Ack_IN = 1'b0;
    Mem_Data_Valid_IN = 1'b1;
    Mem_Data_IN = 32'hAA;
    tick();
    Mem_Data_IN = 32'hBB;
    tick();
    Mem_Data_Valid_IN = 1'b0;
    RESET = 1'b0;
    Read_IN = 1'b0;
    look();
    chk("r_req", Mem_Req_OUT, 0);
    chk("r_maddr", Mem_Addr_OUT, 0);
    chk("r_miss0", Miss_Count_OUT, 0);
    chk("r_hit0", Hit_Count_OUT, 0);
    chk("r_stall", Stall_OUT, 0);
    tick();
    RESET = 1'b1;
    Mem_Data_Valid_IN = 1'b1;
    Mem_Data_IN = 32'hCC;
    look();
    chk("stray_req", Mem_Req_OUT, 0);
    tick();
    Mem_Data_IN = 32'hDD;
    tick();
    Mem_Data_Valid_IN = 1'b0;
    Read_IN = 1'b1;
    Addr_IN = 32'hBFC00040;
    look();
    chk("stray_stall", Stall_OUT, 1);
    chk("stray_instr", Instr_OUT, 0);
    chk("stray_miss0", Miss_Count_OUT, 0);
    chk("stray_idle", Mem_Req_OUT, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
